// File: rtl/dmem_access_unit.sv
// dmem_access_unit
//   Memory-stage access controller. Takes one load/store request per
//   handshake (byte address from the ALU, store data from regfile rd2),
//   runs it on a word-addressed data-memory bus with variable wait states,
//   and returns exactly one response pulse per request. Misaligned requests
//   and accesses that time out come back with resp_err=1.
//
// Ports
//   clk, reset              clock; asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_we/addr/wdata       store flag, byte address, store data
//   resp_valid/rdata/err    one-cycle response, load data, error flag
//   mem_en/we/addr/wdata    bus request (word address), held during ACCESS
//   mem_ack/mem_rdata       bus completion and read data
//   err_count               saturating count of error responses
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a request; misaligned ones go straight to RESP
// ACCESS | bus request outstanding, waiting for mem_ack or timeout
// RESP   | resp_valid high for this single cycle
module dmem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Counter holds the ACCESS edges remaining before abort; the edge that
  // sees it at zero is the TIMEOUT-th edge in ACCESS.
  localparam logic [7:0] TC_LOAD = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [7:0]  err_count_q, err_count_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_addr[1:0] != 2'b00) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d     = ACCESS;
            cnt_d       = TC_LOAD;
            mem_en_d    = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = req_addr[31:2];
            mem_wdata_d = req_wdata;
          end
        end
      end
      ACCESS: begin
        // Ack is checked first so an ack on the final edge still succeeds.
        if (mem_ack) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = mem_we_q ? 32'h0 : mem_rdata;
          mem_en_d     = 1'b0;
          mem_we_d     = 1'b0;
        end else if (cnt_q == 8'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h0;
          mem_en_d     = 1'b0;
          mem_we_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    err_count_d = err_count_q;
    if (resp_valid_q && resp_err_q && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 30'd0;
      mem_wdata_q  <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign err_count  = err_count_q;

endmodule
